// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types and defaults for the counter sequencer.
// State encoding is 3 bits: IDLE=0, CLEAR=1, RUN=2, PAUSE=3, DONE=4.
package counter_seq_ctrl_pkg;

  localparam int DEF_CNT_W = 7;
  localparam int DEF_RUN_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Host/counter-side signal bundle for the counter sequencer.
// The master side is the host plus the counter, and it supplies count.
// The slave side is the sequencer.
interface counter_seq_ctrl_if
  import counter_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             mode;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] count;
  logic             cnt_clr;
  logic             cnt_en;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, pause, mode, limit, count,
    input  cnt_clr, cnt_en, busy, done
  );

  modport slave (
    input  start, stop, pause, mode, limit, count,
    output cnt_clr, cnt_en, busy, done
  );
endinterface

// File: rtl/counter_seq_ctrl_run_tally.sv
// run_tally: saturating tally of completed runs.
// It increments once per cycle while i_inc is high and sticks at all-ones.
// Only reset clears it.
module run_tally #(
  parameter int RUN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [RUN_W-1:0] o_count
);
  logic [RUN_W-1:0] r_count;

  // Saturating increment; the count holds once it reaches all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_count <= '0;
    else if (i_inc && r_count != '1) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequencer for an external up counter.
// It clears the counter, enables it, halts it at a captured limit, and pulses done.
// Define COUNTER_SEQ_CTRL_TALLY_EN to add the run_cnt completed-run tally.
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
`ifdef COUNTER_SEQ_CTRL_TALLY_EN
  , parameter int RUN_W = DEF_RUN_W
`endif
) (
  input  logic              clk,
  input  logic              res,
  counter_seq_ctrl_if.slave bus
`ifdef COUNTER_SEQ_CTRL_TALLY_EN
  , output logic [RUN_W-1:0] run_cnt
`endif
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_limit_q;
  logic             r_mode_q;
  logic             w_terminal;

  assign w_terminal = (bus.count == r_limit_q);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge res) begin
    if (!res) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Capture limit and mode only when a start is accepted.
  // Changes made during a run therefore wait for the next run.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_limit_q <= '0;
      r_mode_q  <= 1'b0;
    end else if (r_state == ST_IDLE && bus.start) begin
      r_limit_q <= bus.limit;
      r_mode_q  <= bus.mode;
    end
  end

  // Next-state logic.
  // In RUN the priority is stop, then terminal, then pause.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_CLEAR;
      ST_CLEAR: w_next = ST_RUN;
      ST_RUN: begin
        if (bus.stop)       w_next = ST_IDLE;
        else if (w_terminal) w_next = ST_DONE;
        else if (bus.pause)  w_next = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (bus.stop)        w_next = ST_IDLE;
        else if (!bus.pause) w_next = ST_RUN;
      end
      ST_DONE:  w_next = (bus.stop || !r_mode_q) ? ST_IDLE : ST_CLEAR;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Output decode.
  // cnt_en is also gated by count so the counter halts exactly on the limit.
  always_comb begin
    bus.cnt_clr = (r_state == ST_CLEAR);
    bus.cnt_en  = (r_state == ST_RUN) && !w_terminal;
    bus.busy    = (r_state != ST_IDLE);
    bus.done    = (r_state == ST_DONE);
  end

`ifdef COUNTER_SEQ_CTRL_TALLY_EN
  run_tally #(.RUN_W(RUN_W)) u_run_tally (
    .clk     (clk),
    .rst_n   (res),
    .i_inc   (r_state == ST_DONE),
    .o_count (run_cnt)
  );
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl.
// A behavioural 7-bit counter closes the loop: it clears on cnt_clr, increments on cnt_en,
// and is never reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_counter_seq_ctrl;

  logic clk;
  logic res;
  logic [6:0] count_q;
  int vectors;
  int miscompares;

  counter_seq_ctrl_if #(.CNT_W(7)) bus ();
  assign bus.count = count_q;

`ifdef COUNTER_SEQ_CTRL_TALLY_EN
  logic [1:0] run_cnt;
  counter_seq_ctrl #(.CNT_W(7), .RUN_W(2)) dut (
    .clk(clk), .res(res), .bus(bus.slave), .run_cnt(run_cnt));
`else
  counter_seq_ctrl #(.CNT_W(7)) dut (.clk(clk), .res(res), .bus(bus.slave));
`endif

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial count_q = '0;
  always @(posedge clk) begin
    if (bus.cnt_clr)     count_q <= '0;
    else if (bus.cnt_en) count_q <= count_q + 7'd1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // The sequencer is in CLEAR at the negedge after this task returns.
  task automatic do_start(input logic [6:0] lim, input logic md);
    bus.start = 1'b1; bus.limit = lim; bus.mode = md;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b0;
    tick();
    vectors++;
    if ({bus.busy, bus.cnt_clr, bus.cnt_en, bus.done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 0000",
               {bus.busy, bus.cnt_clr, bus.cnt_en, bus.done});
    end
    res = 1'b1;
    tick();
    do_start(7'd20, 1'b0);
    tick();
    repeat (5) tick();
    vectors++;
    if (count_q !== 7'd5) begin
      miscompares++; $display("FAIL reset_pre_count: got %0d want 5", count_q);
    end
    #5 res = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.cnt_en, bus.done} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_midrun: got %b want 000", {bus.busy, bus.cnt_en, bus.done});
    end
    @(posedge clk); #1;
    vectors++;
    if (count_q !== 7'd5) begin
      miscompares++; $display("FAIL reset_count_held: got %0d want 5", count_q);
    end
    @(negedge clk);
    res = 1'b1;
    tick();
  endtask

  task automatic test_oneshot();
    do_start(7'd10, 1'b0);
    vectors++;
    if ({bus.cnt_clr, bus.cnt_en, bus.busy} !== 3'b101) begin
      miscompares++;
      $display("FAIL os_clear: got %b want 101", {bus.cnt_clr, bus.cnt_en, bus.busy});
    end
    tick();
    for (int i = 0; i <= 10; i++) begin
      vectors++;
      if (count_q !== 7'(i) || bus.cnt_en !== (i != 10) || bus.done !== 1'b0
          || bus.cnt_clr !== 1'b0) begin
        miscompares++;
        $display("FAIL os_run[%0d]: got count=%0d en=%b done=%b clr=%b want count=%0d en=%b",
                 i, count_q, bus.cnt_en, bus.done, bus.cnt_clr, i, (i != 10));
      end
      tick();
    end
    vectors++;
    if (bus.done !== 1'b1 || count_q !== 7'd10 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL os_done: got done=%b count=%0d busy=%b want 1/10/1",
               bus.done, count_q, bus.busy);
    end
    tick();
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || count_q !== 7'd10) begin
      miscompares++;
      $display("FAIL os_idle: got busy=%b done=%b count=%0d want 0/0/10",
               bus.busy, bus.done, count_q);
    end
    tick();
    vectors++;
    if (count_q !== 7'd10 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL os_hold: got count=%0d done=%b want 10/0", count_q, bus.done);
    end
  endtask

  task automatic test_autoreload();
    do_start(7'd3, 1'b1);
    // One period: CLEAR, RUN0..RUN3, DONE.
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 6; c++) begin
        vectors++;
        if (bus.cnt_clr !== (c == 0) || bus.done !== (c == 5) || bus.busy !== 1'b1
            || (c >= 1 && c <= 4 && count_q !== 7'(c - 1))) begin
          miscompares++;
          $display("FAIL ar[%0d.%0d]: got clr=%b done=%b busy=%b count=%0d want clr=%b done=%b",
                   p, c, bus.cnt_clr, bus.done, bus.busy, count_q, (c == 0), (c == 5));
        end
        tick();
      end
    end
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || count_q !== 7'd1) begin
      miscompares++;
      $display("FAIL ar_stop: got busy=%b done=%b count=%0d want 0/0/1",
               bus.busy, bus.done, count_q);
    end
  endtask

  task automatic test_pause_abort();
    do_start(7'd20, 1'b0);
    tick();
    repeat (6) tick();
    bus.pause = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (count_q !== 7'd7 || bus.cnt_en !== 1'b0 || bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL pause_hold[%0d]: got count=%0d en=%b busy=%b want 7/0/1",
                 k, count_q, bus.cnt_en, bus.busy);
      end
      if (k < 3) tick();
    end
    bus.pause = 1'b0;
    tick();
    vectors++;
    if (count_q !== 7'd7 || bus.cnt_en !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_resume: got count=%0d en=%b want 7/1", count_q, bus.cnt_en);
    end
    tick();
    vectors++;
    if (count_q !== 7'd8) begin
      miscompares++; $display("FAIL pause_next: got %0d want 8", count_q);
    end
    repeat (3) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || count_q !== 7'd12) begin
      miscompares++;
      $display("FAIL abort: got busy=%b done=%b count=%0d want 0/0/12",
               bus.busy, bus.done, count_q);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0 || count_q !== 7'd12) begin
      miscompares++;
      $display("FAIL abort_hold: got done=%b count=%0d want 0/12", bus.done, count_q);
    end
  endtask

  task automatic test_boundaries();
    // A limit of 0 gives DONE two cycles after CLEAR.
    do_start(7'd0, 1'b0);
    tick();
    vectors++;
    if (bus.cnt_en !== 1'b0 || bus.done !== 1'b0 || count_q !== 7'd0) begin
      miscompares++;
      $display("FAIL lim0_run: got en=%b done=%b count=%0d want 0/0/0",
               bus.cnt_en, bus.done, count_q);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b1 || count_q !== 7'd0) begin
      miscompares++;
      $display("FAIL lim0_done: got done=%b count=%0d want 1/0", bus.done, count_q);
    end
    tick();
    // A limit of 127 counts fully and does not wrap.
    do_start(7'd127, 1'b0);
    tick();
    for (int i = 0; i <= 127; i++) begin
      vectors++;
      if (count_q !== 7'(i) || bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL lim127[%0d]: got count=%0d done=%b", i, count_q, bus.done);
      end
      tick();
    end
    vectors++;
    if (bus.done !== 1'b1 || count_q !== 7'd127) begin
      miscompares++;
      $display("FAIL lim127_done: got done=%b count=%0d want 1/127", bus.done, count_q);
    end
    tick();
    vectors++;
    if (bus.busy !== 1'b0 || count_q !== 7'd127) begin
      miscompares++;
      $display("FAIL lim127_nowrap: got busy=%b count=%0d want 0/127", bus.busy, count_q);
    end
    // A start while busy is ignored, and the originally captured limit and mode stay.
    do_start(7'd5, 1'b0);
    tick();
    bus.start = 1'b1; bus.limit = 7'd2; bus.mode = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    vectors++;
    if (count_q !== 7'd5 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_run: got count=%0d done=%b want 5/0", count_q, bus.done);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++; $display("FAIL busy_start_done: got %b want 1", bus.done);
    end
    tick();
    vectors++;
    if (bus.busy !== 1'b0 || count_q !== 7'd5) begin
      miscompares++;
      $display("FAIL busy_start_idle: got busy=%b count=%0d want 0/5", bus.busy, count_q);
    end
    // When pause and the terminal count coincide, the terminal count wins.
    do_start(7'd4, 1'b0);
    tick();
    repeat (4) tick();
    bus.pause = 1'b1;
    tick();
    vectors++;
    if (bus.done !== 1'b1 || count_q !== 7'd4) begin
      miscompares++;
      $display("FAIL pause_term: got done=%b count=%0d want 1/4", bus.done, count_q);
    end
    bus.pause = 1'b0;
    tick();
    // When stop and the terminal count coincide, stop wins and no done pulses.
    do_start(7'd2, 1'b0);
    tick();
    repeat (2) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || count_q !== 7'd2) begin
      miscompares++;
      $display("FAIL stop_term: got done=%b busy=%b count=%0d want 0/0/2",
               bus.done, bus.busy, count_q);
    end
  endtask

`ifdef COUNTER_SEQ_CTRL_TALLY_EN
  task automatic test_tally();
    logic [1:0] exp_tally [5];
    exp_tally = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    res = 1'b0;
    tick();
    res = 1'b1;
    tick();
    vectors++;
    if (run_cnt !== 2'd0) begin
      miscompares++; $display("FAIL tally_reset: got %0d want 0", run_cnt);
    end
    for (int r = 0; r < 5; r++) begin
      do_start(7'd1, 1'b0);
      repeat (4) tick();
      vectors++;
      if (run_cnt !== exp_tally[r]) begin
        miscompares++;
        $display("FAIL tally[%0d]: got %0d want %0d", r, run_cnt, exp_tally[r]);
      end
    end
  endtask
`endif

  initial begin
    vectors = 0; miscompares = 0;
    res = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.mode = 1'b0; bus.limit = '0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_pause_abort();
    test_boundaries();
`ifdef COUNTER_SEQ_CTRL_TALLY_EN
    test_tally();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
